sobel_cfg_loader: RTL

//  MemSplit32 initiator that programs a Sobel filter slave with a 3x3 kernel.
//  - On start: writes the window-size SFR, then writes 9 coefficients into the

---
 rtl/sobel_pkg.sv | 46 ++++
 rtl/memsplit32_if.sv | 23 ++
 rtl/sobel_kernel_rom.sv | 19 +
 rtl/sobel_cfg_loader.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types, FSM encoding and coefficient tables for the Sobel filter configuration loader.
// The read-back states exist only when SOBEL_LOADER_VERIFY_EN is defined.
package sobel_pkg;

  typedef logic signed [15:0] coef_t;

`ifdef SOBEL_LOADER_VERIFY_EN
  typedef enum logic [2:0] {
    IDLE,
    WR_WSIZE,
    WR_COEF,
    RD_COEF,
    WAIT_RESP,
    FIN
  } loader_state_e;
`else
  typedef enum logic [2:0] {
    IDLE,
    WR_WSIZE,
    WR_COEF,
    FIN
  } loader_state_e;
`endif

  localparam int unsigned KSIZE_DEF = 3;
  localparam int unsigned NCOEF_DEF = KSIZE_DEF * KSIZE_DEF;

  // Row-major, idx = r*3 + c
  localparam coef_t SOBEL_GX [9] = '{
    -16'sd1, 16'sd0, 16'sd1,
    -16'sd2, 16'sd0, 16'sd2,
    -16'sd1, 16'sd0, 16'sd1
  };

  localparam coef_t SOBEL_GY [9] = '{
    -16'sd1, -16'sd2, -16'sd1,
     16'sd0,  16'sd0,  16'sd0,
     16'sd1,  16'sd2,  16'sd1
  };

  // Coefficients go onto the 32-bit bus sign-extended
  function automatic logic [31:0] sext_coef(input coef_t c);
    return {{16{c[15]}}, c};
  endfunction

endpackage

// File: rtl/memsplit32_if.sv
// MemSplit32 bus: single-beat request/ack with a separate read-response strobe.
interface MemSplit32;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ack;
  logic        resp;
  logic [31:0] rdata;

  modport Master (
    output req, we, addr, be, wdata,
    input  ack, resp, rdata
  );

  modport Slave (
    input  req, we, addr, be, wdata,
    output ack, resp, rdata
  );

endinterface

// File: rtl/sobel_kernel_rom.sv
// Combinational Sobel kernel table: (sel, idx) -> 16-bit signed coefficient.
// sel = 0 selects Gx, sel = 1 selects Gy; indices beyond the last coefficient read as zero.
module sobel_kernel_rom
  import sobel_pkg::*;
(
  input  logic       sel,
  input  logic [3:0] idx,
  output coef_t      coef
);

  // Table lookup with an out-of-range guard
  always_comb begin
    coef = '0;
    if (idx < 4'(NCOEF_DEF)) begin
      coef = sel ? SOBEL_GY[idx] : SOBEL_GX[idx];
    end
  end

endmodule

// File: rtl/sobel_cfg_loader.sv
// MemSplit32 initiator that programs a Sobel filter: one window-size SFR write,
// then the nine coefficients of the selected kernel (Gx or Gy).
// Define SOBEL_LOADER_VERIFY_EN to read back and compare every coefficient;
// a mismatch sets the sticky err flag, which the next accepted start clears.
module sobel_cfg_loader
  import sobel_pkg::*;
#(
  parameter logic [31:0] WSIZE_ADDR  = 32'h0010_0032,
  parameter logic [31:0] COEF_BASE   = 32'h0010_0040,
  parameter logic [31:0] COEF_STRIDE = 32'd1,
  parameter int unsigned KSIZE       = KSIZE_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      start,
  input  logic      kernel_sel,
  output logic      busy,
  output logic      done,
  output logic      err,
  MemSplit32.Master mif
);

  localparam logic [3:0] LAST_IDX = 4'(KSIZE * KSIZE - 1);

`ifdef SOBEL_LOADER_VERIFY_EN
  localparam loader_state_e AFTER_WRITES = RD_COEF;
`else
  localparam loader_state_e AFTER_WRITES = FIN;
`endif

  loader_state_e state;
  loader_state_e state_nx;

  logic        sel;
  logic [3:0]  idx;
  coef_t       coef;
  logic [31:0] coef_addr;
  logic        at_last;
  logic        accept;

  sobel_kernel_rom u_rom (
    .sel  (sel),
    .idx  (idx),
    .coef (coef)
  );

  assign coef_addr = COEF_BASE + 32'(idx) * COEF_STRIDE;
  assign at_last   = (idx == LAST_IDX);
  assign accept    = (state == IDLE) && start;

  // State register; reset abandons any partial load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state: advance only on handshake completion, no timeout
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (start) state_nx = WR_WSIZE;
      WR_WSIZE:  if (mif.ack) state_nx = WR_COEF;
      WR_COEF:   if (mif.ack && at_last) state_nx = AFTER_WRITES;
`ifdef SOBEL_LOADER_VERIFY_EN
      RD_COEF:   if (mif.ack) state_nx = WAIT_RESP;
      WAIT_RESP: if (mif.resp) state_nx = at_last ? FIN : RD_COEF;
`endif
      FIN:       state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Bus and status outputs decoded from state; fields only move when idx/state move, i.e. after ack
  always_comb begin
    mif.req   = 1'b0;
    mif.we    = 1'b0;
    mif.addr  = '0;
    mif.be    = '0;
    mif.wdata = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      WR_WSIZE: begin
        mif.req   = 1'b1;
        mif.we    = 1'b1;
        mif.be    = '1;
        mif.addr  = WSIZE_ADDR;
        mif.wdata = 32'(KSIZE);
        busy      = 1'b1;
      end
      WR_COEF: begin
        mif.req   = 1'b1;
        mif.we    = 1'b1;
        mif.be    = '1;
        mif.addr  = coef_addr;
        mif.wdata = sext_coef(coef);
        busy      = 1'b1;
      end
`ifdef SOBEL_LOADER_VERIFY_EN
      RD_COEF: begin
        mif.req  = 1'b1;
        mif.be   = '1;
        mif.addr = coef_addr;
        busy     = 1'b1;
      end
      WAIT_RESP: begin
        mif.addr = coef_addr;
        busy     = 1'b1;
      end
`endif
      FIN: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Kernel select latch and coefficient index; idx restarts at 0 for the read-back pass
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel <= 1'b0;
      idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sel <= kernel_sel;
            idx <= '0;
          end
        end
        WR_WSIZE: begin
          if (mif.ack) idx <= '0;
        end
        WR_COEF: begin
          if (mif.ack) idx <= at_last ? '0 : idx + 4'd1;
        end
`ifdef SOBEL_LOADER_VERIFY_EN
        WAIT_RESP: begin
          if (mif.resp && !at_last) idx <= idx + 4'd1;
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef SOBEL_LOADER_VERIFY_EN
  logic mismatch;
  assign mismatch = (mif.rdata[15:0] != coef);

  // Sticky verify flag: cleared by an accepted start, set by any read-back mismatch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (accept) begin
      err <= 1'b0;
    end else if ((state == WAIT_RESP) && mif.resp && mismatch) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_rd;
  assign err       = 1'b0;
  assign unused_rd = ^{mif.resp, mif.rdata, accept};
`endif

endmodule
